halt_ctl: RTL and testbench
===========================

Name: halt_ctl

Overview:
Upstream neighbour of the cycle/instruction counter. Watches the writeback stage and counts retired instructions. When a halt retires, it waits for the pipeline and memory to drain, then raises the one-cycle `isHalt` strobe that the counter uses to print final statistics. It also contains the simulation watchdogs (no-retire stall and global cycle timeout), which force a halt so a hung run still terminates with a report.

Parameters:
DRAIN_CYCLES, 4, number of idle drain cycles required after halt retires (counted only while mem_busy=0)
STALL_LIMIT, 1000, consecutive cycles without W_v in RUN before a stall error forces halt
MAX_CYCLES, 100000, cycle value at which a timeout forces halt
CW, 32, width of the cycle input

Ports:
clk  in  1  system clock; all logic on posedge clk
reset  in  1  synchronous, active-high; sampled on posedge clk
W_v  in  1  writeback valid: one instruction retires this cycle
W_halt  in  1  retiring instruction is a halt; meaningful only when W_v=1
mem_busy  in  1  outstanding memory writes; blocks drain progress
cycle  in  CW  free-running cycle count from the counter
isHalt  out  1  one-cycle strobe, high only in state HALT
halted  out  1  high in HALT and DONE; sticky until reset
retired  out  32  retired-instruction count, saturating
stall_err  out  1  sticky: halt was forced by the stall watchdog
timeout  out  1  sticky: halt was forced by the cycle timeout
state  out  2  RUN=0, DRAIN=1, HALT=2, DONE=3

Behaviour:
- Reset (synchronous): state=RUN. retired, idle counter, drain counter, stall_err and timeout all 0. isHalt=0, halted=0. Reset at any time, including mid-DRAIN or DONE, aborts with no isHalt pulse.
- All outputs are registered or decoded from the state register. No combinational path from inputs to outputs.
- retired increments on every W_v=1 cycle in RUN only, including the halt instruction itself. W_v in DRAIN, HALT or DONE is ignored. Saturates at 2^32-1.
- RUN:
  - idle counter resets to 0 on W_v=1; otherwise it increments.
  - Transitions are evaluated each cycle in this priority order:
    1. cycle >= MAX_CYCLES-1: set timeout, next state HALT.
    2. W_v & W_halt: next state DRAIN, drain counter = DRAIN_CYCLES.
    3. W_v=0 & idle == STALL_LIMIT-1: set stall_err, next state HALT.
    4. Otherwise stay in RUN.
- DRAIN:
  - Timeout check is still active: cycle >= MAX_CYCLES-1 sets timeout and goes to HALT.
  - Else if mem_busy=1: hold the drain counter.
  - Else if drain counter == 0: go to HALT.
  - Else decrement the drain counter.
  - The minimum stay in DRAIN is DRAIN_CYCLES+1 cycles.
- HALT: lasts exactly one cycle; isHalt=1, halted=1; then unconditionally go to DONE.
- DONE: terminal. halted=1, isHalt=0, stall_err and timeout hold their values. Exit only by reset.
- At most one isHalt pulse per reset epoch.
- stall_err and timeout are mutually exclusive within an epoch; the first forced cause wins.
- Counter widths:
  - idle counter: clog2(STALL_LIMIT)+1 bits, saturates at the limit.
  - drain counter: clog2(DRAIN_CYCLES)+1 bits.
  - cycle comparison is unsigned, CW bits.

Test Plan:
1. Normal halt (DRAIN_CYCLES=4, mem_busy=0). Release reset at cycle 0; W_v=1 on cycles 1..10; W_v=1 & W_halt=1 on cycle 12. Required: state=DRAIN on cycles 13..17, isHalt=1 only on cycle 18, state=DONE from 19, retired=11, stall_err=0, timeout=0.
2. Memory drain hold. Same as scenario 1, but mem_busy=1 on cycles 14..16. Required: isHalt moves to cycle 21, retired=11.
3. Stall watchdog (STALL_LIMIT=8). No W_v after reset. Required: isHalt on cycle 8, stall_err=1, timeout=0, retired=0. A single W_v at cycle 5 delays isHalt to cycle 14.
4. Timeout (MAX_CYCLES=50). W_v=1 every cycle, no halt, cycle input driven from 0. Required: isHalt in the cycle after cycle=49, timeout=1, stall_err=0, retired=49.
5. Post-halt traffic and priority. After isHalt, 5 more W_v pulses: retired unchanged, halted stays 1. W_v & W_halt in the same cycle as cycle=MAX_CYCLES-1: timeout=1, HALT is entered directly without DRAIN, and that instruction is counted.
6. Reset mid-operation. Assert reset during DRAIN cycle 15 of scenario 1. Required: next cycle state=RUN, retired=0, no isHalt pulse. A subsequent halt sequence behaves exactly as in scenario 1.

Source files
------------

// File: rtl/halt_ctl.sv
// Halt controller: counts retired instructions, drains after a halt retires, then strobes isHalt once.
// Latency: isHalt rises DRAIN_CYCLES+2 cycles after the halt retires (plus mem_busy hold cycles); forced halts strobe next cycle.
// Backpressure: mem_busy freezes drain progress; W_v outside RUN is ignored; watchdogs force a halt on stall/timeout.
module halt_ctl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int STALL_LIMIT  = 1000,
  parameter int MAX_CYCLES   = 100000,
  parameter int CW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          W_v,
  input  logic          W_halt,
  input  logic          mem_busy,
  input  logic [CW-1:0] cycle,
  output logic          isHalt,
  output logic          halted,
  output logic [31:0]   retired,
  output logic          stall_err,
  output logic          timeout,
  output logic [1:0]    state
);

  localparam int IW = $clog2(STALL_LIMIT) + 1;
  localparam int DW = $clog2(DRAIN_CYCLES) + 1;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IW-1:0] IDLE_LAST  = IW'(STALL_LIMIT - 1);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(STALL_LIMIT);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);
  localparam logic [CW-1:0] CYC_LAST   = CW'(MAX_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [31:0]   retired_q, retired_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          stall_err_q, stall_err_d;
  logic          timeout_q, timeout_d;

  // Event qualifiers shared by the next-state and counter logic.
  logic timeout_hit, halt_ret, stall_hit;
  assign timeout_hit = (cycle >= CYC_LAST);
  assign halt_ret    = W_v & W_halt;
  assign stall_hit   = ~W_v & (idle_q == IDLE_LAST);

  // State and counter registers; synchronous reset aborts any epoch without a strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      retired_q   <= '0;
      idle_q      <= '0;
      drain_q     <= '0;
      stall_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      retired_q   <= retired_d;
      idle_q      <= idle_d;
      drain_q     <= drain_d;
      stall_err_q <= stall_err_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next state: timeout beats a retiring halt, which beats the stall watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (timeout_hit)    state_d = S_HALT;
        else if (halt_ret)  state_d = S_DRAIN;
        else if (stall_hit) state_d = S_HALT;
      end
      S_DRAIN: begin
        if (timeout_hit)                         state_d = S_HALT;
        else if (!mem_busy && (drain_q == '0))   state_d = S_HALT;
      end
      S_HALT:  state_d = S_DONE;
      default: state_d = S_DONE;
    endcase
  end

  // Counters and sticky cause flags; only RUN counts retires, only DRAIN consumes the drain budget.
  always_comb begin
    retired_d   = retired_q;
    idle_d      = idle_q;
    drain_d     = drain_q;
    stall_err_d = stall_err_q;
    timeout_d   = timeout_q;
    case (state_q)
      S_RUN: begin
        if (W_v && (retired_q != 32'hFFFF_FFFF)) retired_d = retired_q + 32'd1;
        if (W_v)                    idle_d = '0;
        else if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
        if (timeout_hit)    timeout_d   = 1'b1;
        else if (halt_ret)  drain_d     = DRAIN_INIT;
        else if (stall_hit) stall_err_d = 1'b1;
      end
      S_DRAIN: begin
        if (timeout_hit) timeout_d = 1'b1;
        else if (!mem_busy && (drain_q != '0)) drain_d = drain_q - 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs decoded purely from registers.
  always_comb begin
    isHalt    = (state_q == S_HALT);
    halted    = state_q[1];
    retired   = retired_q;
    stall_err = stall_err_q;
    timeout   = timeout_q;
    state     = state_q;
  end

endmodule

// File: tb/tb_halt_ctl.sv
// Bench for halt_ctl: directed scenarios plus randomized epochs checked against a trace-level model.
// Cycle k = interval after the k-th rising edge following the last reset edge; outputs sampled on negedge.
// All waits are fixed-length loops so the run always terminates.
module tb_halt_ctl;

  localparam int DRAIN = 4;
  localparam int STALL = 8;
  localparam int MAXC  = 50;
  localparam int N     = 128;

  logic        clk = 1'b0;
  logic        reset, W_v, W_halt, mem_busy;
  logic [31:0] cycle;
  logic        isHalt, halted, stall_err, timeout;
  logic [31:0] retired;
  logic [1:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  logic        wv_a[N], wh_a[N], mb_a[N], rs_a[N];
  int          cy_a[N];
  int          o_state[N];
  logic        o_ish[N], o_hlt[N], o_se[N], o_to[N];
  logic [31:0] o_ret[N];

  halt_ctl #(.DRAIN_CYCLES(DRAIN), .STALL_LIMIT(STALL), .MAX_CYCLES(MAXC), .CW(32)) dut (
    .clk(clk), .reset(reset), .W_v(W_v), .W_halt(W_halt), .mem_busy(mem_busy),
    .cycle(cycle), .isHalt(isHalt), .halted(halted), .retired(retired),
    .stall_err(stall_err), .timeout(timeout), .state(state)
  );

  always #5 clk = ~clk;

  task automatic clear_stim();
    for (int k = 0; k < N; k++) begin
      wv_a[k] = 1'b0; wh_a[k] = 1'b0; mb_a[k] = 1'b0; rs_a[k] = 1'b0; cy_a[k] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; W_v = 1'b0; W_halt = 1'b0; mem_busy = 1'b0; cycle = '0;
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic drive(input int len);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      o_state[k] = int'(state); o_ish[k] = isHalt; o_hlt[k] = halted;
      o_se[k] = stall_err; o_to[k] = timeout; o_ret[k] = retired;
      reset = rs_a[k]; W_v = wv_a[k]; W_halt = wh_a[k]; mem_busy = mb_a[k];
      cycle = 32'(cy_a[k]);
      @(posedge clk);
    end
  endtask

  function automatic int first_ish(input int lo, input int hi);
    for (int k = lo; k < hi; k++) if (o_ish[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int count_ish(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k < hi; k++) if (o_ish[k] === 1'b1) c++;
    return c;
  endfunction

  // Trace model: scan the stimulus for the first halting event, then derive the strobe cycle.
  // cause: 1 = retired halt, 2 = timeout, 3 = stall watchdog.
  task automatic predict(input int start, input int len, output int t_ev, output int h,
                         output int cause, output int ret);
    int last, idle, cnt;
    last = -1; t_ev = -1; h = -1; cause = 0; ret = 0;
    for (int t = start; t < len; t++) begin
      idle = (last < 0) ? (t - start) : (t - last - 1);
      if (wv_a[t]) ret++;
      if (cy_a[t] >= MAXC - 1) begin
        t_ev = t; h = t + 1; cause = 2; return;
      end
      if (wv_a[t] && wh_a[t]) begin
        t_ev = t; cause = 1; cnt = 0;
        for (int u = t + 1; u < len; u++) begin
          if (cy_a[u] >= MAXC - 1) begin h = u + 1; cause = 2; return; end
          if (!mb_a[u]) begin
            cnt++;
            if (cnt == DRAIN + 1) begin h = u + 1; return; end
          end
        end
        return;
      end
      if (!wv_a[t] && idle == STALL - 1) begin
        t_ev = t; h = t + 1; cause = 3; return;
      end
      if (wv_a[t]) last = t;
    end
  endtask

  task automatic test_reset();
    do_reset();
    clear_stim();
    drive(2);
    n_checks++; if (o_state[0] !== 0) $display("FAIL reset_state got=%0d exp=0", o_state[0]); else n_pass++;
    n_checks++; if (o_ret[0] !== 32'd0) $display("FAIL reset_retired got=%0d exp=0", o_ret[0]); else n_pass++;
    n_checks++; if (o_ish[0] !== 1'b0 || o_hlt[0] !== 1'b0)
      $display("FAIL reset_halt_flags got isHalt=%b halted=%b exp=0/0", o_ish[0], o_hlt[0]); else n_pass++;
    n_checks++; if (o_se[0] !== 1'b0 || o_to[0] !== 1'b0)
      $display("FAIL reset_causes got stall=%b timeout=%b exp=0/0", o_se[0], o_to[0]); else n_pass++;
  endtask

  task automatic load_normal(input int off);
    for (int k = off + 1; k <= off + 10; k++) wv_a[k] = 1'b1;
    wv_a[off + 12] = 1'b1; wh_a[off + 12] = 1'b1;
  endtask

  task automatic test_normal_halt();
    int bad;
    do_reset(); clear_stim(); load_normal(0);
    drive(24);
    bad = 0;
    for (int k = 13; k <= 17; k++) if (o_state[k] !== 1) bad++;
    n_checks++; if (bad != 0 || o_state[12] !== 0)
      $display("FAIL normal_drain_window bad=%0d state12=%0d exp 0 bad, RUN at 12", bad, o_state[12]); else n_pass++;
    n_checks++; if (first_ish(0, 24) !== 18 || count_ish(0, 24) !== 1)
      $display("FAIL normal_ishalt first=%0d pulses=%0d exp 18/1", first_ish(0, 24), count_ish(0, 24)); else n_pass++;
    bad = 0;
    for (int k = 19; k < 24; k++) if (o_state[k] !== 3 || o_hlt[k] !== 1'b1) bad++;
    n_checks++; if (bad != 0) $display("FAIL normal_done bad=%0d exp=0", bad); else n_pass++;
    n_checks++; if (o_ret[23] !== 32'd11) $display("FAIL normal_retired got=%0d exp=11", o_ret[23]); else n_pass++;
    n_checks++; if (o_se[23] !== 1'b0 || o_to[23] !== 1'b0)
      $display("FAIL normal_causes got stall=%b timeout=%b exp=0/0", o_se[23], o_to[23]); else n_pass++;
  endtask

  task automatic test_mem_hold();
    do_reset(); clear_stim(); load_normal(0);
    for (int k = 14; k <= 16; k++) mb_a[k] = 1'b1;
    drive(26);
    n_checks++; if (first_ish(0, 26) !== 21 || count_ish(0, 26) !== 1)
      $display("FAIL memhold_ishalt first=%0d pulses=%0d exp 21/1", first_ish(0, 26), count_ish(0, 26)); else n_pass++;
    n_checks++; if (o_ret[25] !== 32'd11) $display("FAIL memhold_retired got=%0d exp=11", o_ret[25]); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset(); clear_stim();
    drive(12);
    n_checks++; if (first_ish(0, 12) !== 8) $display("FAIL stall_ishalt got=%0d exp=8", first_ish(0, 12)); else n_pass++;
    n_checks++; if (o_se[11] !== 1'b1 || o_to[11] !== 1'b0 || o_ret[11] !== 32'd0)
      $display("FAIL stall_flags got stall=%b timeout=%b retired=%0d exp 1/0/0", o_se[11], o_to[11], o_ret[11]); else n_pass++;
    do_reset(); clear_stim();
    wv_a[5] = 1'b1;
    drive(18);
    n_checks++; if (first_ish(0, 18) !== 14 || o_ret[17] !== 32'd1)
      $display("FAIL stall_delayed got first=%0d retired=%0d exp 14/1", first_ish(0, 18), o_ret[17]); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset(); clear_stim();
    for (int k = 0; k < 56; k++) begin cy_a[k] = k; wv_a[k] = (k >= 1); end
    drive(56);
    n_checks++; if (first_ish(0, 56) !== 50 || count_ish(0, 56) !== 1)
      $display("FAIL timeout_ishalt first=%0d pulses=%0d exp 50/1", first_ish(0, 56), count_ish(0, 56)); else n_pass++;
    n_checks++; if (o_to[55] !== 1'b1 || o_se[55] !== 1'b0 || o_ret[55] !== 32'd49)
      $display("FAIL timeout_flags got timeout=%b stall=%b retired=%0d exp 1/0/49", o_to[55], o_se[55], o_ret[55]); else n_pass++;
  endtask

  task automatic test_post_halt_priority();
    int bad;
    do_reset(); clear_stim(); load_normal(0);
    for (int k = 20; k <= 24; k++) wv_a[k] = 1'b1;
    drive(30);
    bad = 0;
    for (int k = 18; k < 30; k++) if (o_hlt[k] !== 1'b1) bad++;
    n_checks++; if (o_ret[29] !== 32'd11 || bad != 0)
      $display("FAIL posthalt got retired=%0d halted_drops=%0d exp 11/0", o_ret[29], bad); else n_pass++;
    n_checks++; if (count_ish(0, 30) !== 1) $display("FAIL posthalt_pulses got=%0d exp=1", count_ish(0, 30)); else n_pass++;
    do_reset(); clear_stim();
    for (int k = 0; k < 54; k++) begin cy_a[k] = k; wv_a[k] = (k >= 1); end
    wh_a[49] = 1'b1;
    drive(54);
    bad = 0;
    for (int k = 0; k < 54; k++) if (o_state[k] === 1) bad++;
    n_checks++; if (o_state[50] !== 2 || bad != 0)
      $display("FAIL priority_direct_halt state50=%0d drain_cycles=%0d exp 2/0", o_state[50], bad); else n_pass++;
    n_checks++; if (o_to[53] !== 1'b1 || o_se[53] !== 1'b0 || o_ret[53] !== 32'd49)
      $display("FAIL priority_flags got timeout=%b stall=%b retired=%0d exp 1/0/49", o_to[53], o_se[53], o_ret[53]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset(); clear_stim(); load_normal(0);
    rs_a[15] = 1'b1;
    load_normal(16);
    drive(38);
    n_checks++; if (o_state[16] !== 0 || o_ret[16] !== 32'd0)
      $display("FAIL resetmid_abort got state=%0d retired=%0d exp 0/0", o_state[16], o_ret[16]); else n_pass++;
    n_checks++; if (count_ish(0, 17) !== 0) $display("FAIL resetmid_no_pulse got=%0d exp=0", count_ish(0, 17)); else n_pass++;
    bad = 0;
    for (int k = 29; k <= 33; k++) if (o_state[k] !== 1) bad++;
    n_checks++; if (first_ish(17, 38) !== 34 || count_ish(17, 38) !== 1 || bad != 0)
      $display("FAIL resetmid_rerun first=%0d pulses=%0d drain_bad=%0d exp 34/1/0",
               first_ish(17, 38), count_ish(17, 38), bad); else n_pass++;
    n_checks++; if (o_ret[37] !== 32'd11) $display("FAIL resetmid_retired got=%0d exp=11", o_ret[37]); else n_pass++;
  endtask

  task automatic test_random();
    int t_ev, h, cause, ret, pw, ph, pm, cy0, bad_s, bad_r, exp_s, cnt;
    for (int it = 0; it < 20; it++) begin
      do_reset(); clear_stim();
      pw = $urandom_range(100, 0); ph = $urandom_range(15, 0); pm = $urandom_range(70, 0);
      cy0 = $urandom_range(45, 0);
      for (int k = 0; k < 70; k++) begin
        cy_a[k] = cy0 + k;
        wv_a[k] = ($urandom_range(99, 0) < pw);
        wh_a[k] = wv_a[k] && ($urandom_range(99, 0) < ph);
        mb_a[k] = ($urandom_range(99, 0) < pm);
      end
      drive(70);
      predict(0, 70, t_ev, h, cause, ret);
      n_checks++; if (first_ish(0, 70) !== h || count_ish(0, 70) !== 1)
        $display("FAIL rand%0d_ishalt first=%0d pulses=%0d exp %0d/1", it, first_ish(0, 70), count_ish(0, 70), h); else n_pass++;
      bad_s = 0; bad_r = 0; cnt = 0;
      for (int k = 0; k < 70; k++) begin
        exp_s = (k <= t_ev) ? 0 : (k < h) ? 1 : (k == h) ? 2 : 3;
        if (o_state[k] !== exp_s) bad_s++;
        if (o_ret[k] !== 32'(cnt)) bad_r++;
        if (wv_a[k] && k <= t_ev) cnt++;
      end
      n_checks++; if (bad_s != 0 || bad_r != 0)
        $display("FAIL rand%0d_trace state_bad=%0d retired_bad=%0d exp 0/0", it, bad_s, bad_r); else n_pass++;
      n_checks++; if (o_ret[69] !== 32'(ret) || o_to[69] !== (cause == 2) || o_se[69] !== (cause == 3))
        $display("FAIL rand%0d_final got retired=%0d timeout=%b stall=%b exp %0d/%b/%b",
                 it, o_ret[69], o_to[69], o_se[69], ret, (cause == 2), (cause == 3)); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; W_v = 1'b0; W_halt = 1'b0; mem_busy = 1'b0; cycle = '0;
    test_reset();
    test_normal_halt();
    test_mem_hold();
    test_stall();
    test_timeout();
    test_post_halt_priority();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
